ahb3lite_led_gpio: RTL and testbench

// - AHB3-Lite slave peripheral on interconnect slave port 1 (base 0x2000_0000), downstream of ahb3lite_interconnect.
// - Gives the Cortex-M0 software control of the board LEDs (static value plus per-LED blink) and a debounced push button.
// - Single clock domain (10 MHz core clock). Zero wait states for legal accesses; two-cycle ERROR response otherwise.

---
 rtl/ahb3lite_pkg.sv | 45 ++++
 rtl/button_debouncer.sv | 42 ++++
 rtl/ahb3lite_led_gpio.sv | 155 +++++++++++++++
 tb/tb_ahb3lite_led_gpio.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, LED/GPIO register offsets and the error-response FSM states.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] LED_OUT_OFS    = 2'd0;
  localparam logic [1:0] BLINK_MASK_OFS = 2'd1;
  localparam logic [1:0] PRESCALE_OFS   = 2'd2;
  localparam logic [1:0] STATUS_OFS     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE_OK = 2'd0,
    ST_ERR1    = 2'd1,
    ST_ERR2    = 2'd2
  } err_state_t;

  // Unsupported sizes and misaligned halfword/word accesses get an ERROR response.
  function automatic logic access_bad(input logic [2:0] size, input logic [1:0] ofs);
    case (size)
      HSIZE_BYTE:  access_bad = 1'b0;
      HSIZE_HWORD: access_bad = ofs[0];
      HSIZE_WORD:  access_bad = (ofs != 2'b00);
      default:     access_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] ofs);
    case (size)
      HSIZE_BYTE:  lane_strobe = 4'b0001 << ofs;
      HSIZE_HWORD: lane_strobe = ofs[1] ? 4'b1100 : 4'b0011;
      default:     lane_strobe = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stability counter; level_o follows the button once it
// has held a new value for g_cycles consecutive cycles, rise_o pulses on a 0->1 update.
module button_debouncer #(
  parameter int g_cycles = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(g_cycles + 1);
  localparam logic [CW-1:0] LAST = CW'(g_cycles - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      sync_p0 <= raw_i;
      sync_p1 <= sync_p0;
      rise_o  <= 1'b0;
      if (sync_p1 == level_o) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt     <= '0;
        level_o <= sync_p1;
        rise_o  <= sync_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ahb3lite_led_gpio.sv
// AHB3-Lite slave exposing LED value, per-LED blink mask, blink prescaler and a debounced button.
// Zero-wait for legal accesses, two-cycle ERROR response for bad size or misalignment.
module ahb3lite_led_gpio
  import ahb3lite_pkg::*;
#(
  parameter int g_led_num         = 8,
  parameter int g_debounce_cycles = 100000,
  parameter int g_prescale_rst    = 5000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hsel_i,
  input  logic [31:0]          haddr_i,
  input  logic [31:0]          hwdata_i,
  output logic [31:0]          hrdata_o,
  input  logic                 hwrite_i,
  input  logic [2:0]           hsize_i,
  input  logic [1:0]           htrans_i,
  input  logic                 hready_i,
  output logic                 hreadyout_o,
  output logic                 hresp_o,
  input  logic                 button_i,
  output logic [g_led_num-1:0] leds_o
);

  err_state_t           state, state_next;
  logic                 accept, bad;
  logic                 dp_valid, dp_write;
  logic [3:0]           dp_addr;
  logic [3:0]           dp_strb;
  logic [31:0]          wmask, rd_word, wr_word, led_ext, blink_ext;
  logic                 commit;
  logic [g_led_num-1:0] led_out, blink_mask;
  logic [23:0]          prescale, blink_cnt;
  logic                 blink_phase;
  logic                 btn_level, btn_rise, btn_flag;
  logic                 unused_bits;

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur, input logic [31:0] wd,
                                              input logic [31:0] mask);
    merge_lanes = (cur & ~mask) | (wd & mask);
  endfunction

  // Address phase: ERR1 holds hreadyout low, so nothing is accepted there.
  assign accept = hsel_i & hready_i & htrans_i[1] & (state != ST_ERR1);
  assign bad    = access_bad(hsize_i, haddr_i[1:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE_OK;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_strb  <= '0;
    end else begin
      state    <= state_next;
      dp_valid <= accept & ~bad;
      if (accept) begin
        dp_write <= hwrite_i;
        dp_addr  <= haddr_i[3:0];
        dp_strb  <= lane_strobe(hsize_i, haddr_i[1:0]);
      end
    end
  end

  always_comb begin
    state_next  = state;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    case (state)
      ST_IDLE_OK: if (accept && bad) state_next = ST_ERR1;
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_next  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_o    = HRESP_ERROR;
        state_next = (accept && bad) ? ST_ERR1 : ST_IDLE_OK;
      end
      default: state_next = ST_IDLE_OK;
    endcase
  end

  // Data phase: one read mux feeds both hrdata and the byte-lane merge for writes.
  always_comb begin
    led_ext   = '0;
    blink_ext = '0;
    led_ext[g_led_num-1:0]   = led_out;
    blink_ext[g_led_num-1:0] = blink_mask;
    case (dp_addr[3:2])
      LED_OUT_OFS:    rd_word = led_ext;
      BLINK_MASK_OFS: rd_word = blink_ext;
      PRESCALE_OFS:   rd_word = {8'd0, prescale};
      default:        rd_word = {30'd0, btn_flag, btn_level};
    endcase
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{dp_strb[b]}};
  end

  assign wr_word  = merge_lanes(rd_word, hwdata_i, wmask);
  assign commit   = dp_valid & dp_write;
  assign hrdata_o = (dp_valid && !dp_write) ? rd_word : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_out    <= '0;
      blink_mask <= '0;
      prescale   <= 24'(g_prescale_rst);
      btn_flag   <= 1'b0;
    end else begin
      if (commit && dp_addr[3:2] == LED_OUT_OFS)    led_out    <= wr_word[g_led_num-1:0];
      if (commit && dp_addr[3:2] == BLINK_MASK_OFS) blink_mask <= wr_word[g_led_num-1:0];
      if (commit && dp_addr[3:2] == PRESCALE_OFS)   prescale   <= wr_word[23:0];
      if (btn_rise)
        btn_flag <= 1'b1;
      else if (commit && dp_addr[3:2] == STATUS_OFS && wmask[1] && hwdata_i[1])
        btn_flag <= 1'b0;
    end
  end

  // Blink prescaler and registered LED drive.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      leds_o      <= '0;
    end else begin
      if (prescale == 24'd0) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (commit && dp_addr[3:2] == PRESCALE_OFS) begin
        blink_cnt <= '0;
      end else if (blink_cnt == prescale - 24'd1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 24'd1;
      end
      leds_o <= led_out ^ (blink_mask & {g_led_num{blink_phase}});
    end
  end

  button_debouncer #(
    .g_cycles(g_debounce_cycles)
  ) u_debouncer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .raw_i  (button_i),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  assign unused_bits = ^{haddr_i[31:4], htrans_i[0], wr_word};

endmodule

// File: tb/tb_ahb3lite_led_gpio.sv
// Directed bench for ahb3lite_led_gpio: register access, byte lanes, blink, ERROR response,
// debounce/W1C and reset during an error response.
module tb_ahb3lite_led_gpio;
  localparam int LEDS = 8;
  localparam int DEB  = 8;
  localparam int PRE  = 50;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2;

  logic clk = 1'b0;
  logic rst, hsel, hwrite, hready, hreadyout, hresp, button;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0] hsize;
  logic [1:0] htrans;
  logic [LEDS-1:0] leds;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb3lite_led_gpio #(
    .g_led_num(LEDS), .g_debounce_cycles(DEB), .g_prescale_rst(PRE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel), .haddr_i(haddr), .hwdata_i(hwdata),
    .hrdata_o(hrdata), .hwrite_i(hwrite), .hsize_i(hsize), .htrans_i(htrans),
    .hready_i(hready), .hreadyout_o(hreadyout), .hresp_o(hresp),
    .button_i(button), .leds_o(leds)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel = 1'b1; haddr = BASE | a; hwrite = wr; hsize = sz; htrans = 2'b10;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    addr_phase(a, 1'b1, sz);
    tick();
    idle();
    hwdata = d;
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] a, input string tag, input logic [31:0] exp);
    addr_phase(a, 1'b0, SZ_W);
    tick();
    idle();
    check(tag, hrdata, exp);
    check({tag, "_rsp"}, {30'd0, hreadyout, hresp}, 32'h2);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; button = 1'b0; hwdata = '0; haddr = '0; hsize = '0;
    idle();
    repeat (3) tick();
    check("rst_hreadyout", 32'(hreadyout), 32'h1);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    rst = 1'b0;
    tick();
    ahb_read(32'h0, "rst_led_out", 32'h0);
    ahb_read(32'h4, "rst_blink_mask", 32'h0);
    ahb_read(32'h8, "rst_prescale", 32'd50);
    ahb_read(32'hC, "rst_status", 32'h0);

    // Word write, LED latency, readback.
    ahb_write(32'h0, SZ_W, 32'h0000_00A5);
    check("leds_before", 32'(leds), 32'h0);
    tick();
    check("leds_after", 32'(leds), 32'hA5);
    ahb_read(32'h0, "led_a5", 32'hA5);

    // Byte lanes.
    ahb_write(32'h0, SZ_W, 32'h0000_00FF);
    ahb_write(32'h1, SZ_B, 32'h0000_3C00);
    ahb_read(32'h0, "byte_lane1", 32'hFF);
    ahb_write(32'h0, SZ_B, 32'h0000_0012);
    ahb_read(32'h0, "byte_lane0", 32'h12);
    ahb_write(32'h8, SZ_H, 32'h0000_1234);
    ahb_read(32'h8, "hword_low", 32'h0000_1234);
    ahb_write(32'hA, SZ_H, 32'h0056_0000);
    ahb_read(32'h8, "hword_high", 32'h0056_1234);

    // Blink with PRESCALE=4.
    ahb_write(32'h8, SZ_W, 32'h0);
    ahb_write(32'h4, SZ_W, 32'h0F);
    ahb_write(32'h0, SZ_W, 32'h0);
    ahb_write(32'h8, SZ_W, 32'd4);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("blink_%0d", i), 32'(leds), (((i - 1) / 4) % 2 == 1) ? 32'h0F : 32'h00);
    end
    ahb_write(32'h8, SZ_W, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("blink_off", 32'(leds), 32'h0);
    end

    // Misaligned word read, then back-to-back valid read.
    ahb_write(32'h0, SZ_W, 32'h77);
    addr_phase(32'h2, 1'b0, SZ_W);
    tick();
    check("err1_rdy", 32'(hreadyout), 32'h0);
    check("err1_resp", 32'(hresp), 32'h1);
    addr_phase(32'h0, 1'b0, SZ_W);
    tick();
    check("err2_rdy", 32'(hreadyout), 32'h1);
    check("err2_resp", 32'(hresp), 32'h1);
    tick();
    idle();
    check("after_err_rdy", 32'(hreadyout), 32'h1);
    check("after_err_resp", 32'(hresp), 32'h0);
    check("after_err_data", hrdata, 32'h77);
    tick();

    // Illegal size and misaligned write.
    addr_phase(32'h0, 1'b0, 3'd3);
    tick();
    check("size3_resp", {30'd0, hreadyout, hresp}, 32'h1);
    idle();
    tick();
    tick();
    check("size3_done", 32'(hresp), 32'h0);
    ahb_write(32'h1, SZ_H, 32'hFFFF_FFFF);
    tick();
    ahb_read(32'h0, "misaligned_nocommit", 32'h77);

    // Debounce, sticky rise flag, W1C.
    button = 1'b1;
    repeat (3) tick();
    button = 1'b0;
    repeat (12) tick();
    ahb_read(32'hC, "status_glitch", 32'h0);
    button = 1'b1;
    repeat (20) tick();
    ahb_read(32'hC, "status_pressed", 32'h3);
    ahb_write(32'hC, SZ_W, 32'h2);
    ahb_read(32'hC, "status_w1c", 32'h1);
    button = 1'b0;
    repeat (15) tick();
    ahb_read(32'hC, "status_released", 32'h0);

    // Reset asserted during ERR1.
    ahb_write(32'h0, SZ_W, 32'h33);
    ahb_write(32'h4, SZ_W, 32'h0F);
    tick();
    check("pre_rst_leds", 32'(leds), 32'h33);
    addr_phase(32'h3, 1'b1, SZ_H);
    tick();
    check("pre_rst_err1", 32'(hreadyout), 32'h0);
    rst = 1'b1;
    idle();
    tick();
    check("mid_rst_rdy", 32'(hreadyout), 32'h1);
    check("mid_rst_resp", 32'(hresp), 32'h0);
    check("mid_rst_leds", 32'(leds), 32'h0);
    rst = 1'b0;
    tick();
    ahb_read(32'h0, "post_rst_led", 32'h0);
    ahb_read(32'h4, "post_rst_blink", 32'h0);
    ahb_read(32'h8, "post_rst_prescale", 32'd50);
    ahb_read(32'hC, "post_rst_status", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
